// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   - fetch_st_e      : sequencer state encoding (2 bits)
//   - FETCH_RESET_PC  : core reset entrance, first fetch address
//   - FETCH_ADDR_W    : address / instruction width
//   - EXC_* indices   : where if_excp_ade lands in the pipeline ExcBus
package fetch_ctrl_pkg;

    localparam int          FETCH_ADDR_W   = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'hBFC0_0000;

    // ExcBus layout seen by decode: one bit per exception code, fetch
    // address errors map onto AdEL.
    localparam int EXC_BUS_W      = 32;
    localparam int EXC_IDX_ADEL   = 4;
    localparam int EXC_IDX_IF_ADE = EXC_IDX_ADEL;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_st_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-bus handshake bundle.
//   master : fetch side, drives ibus_req/ibus_addr, samples the acks/data
//   slave  : memory side
interface fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              ibus_req;
    logic [ADDR_W-1:0] ibus_addr;
    logic              ibus_addr_ok;
    logic              ibus_data_ok;
    logic [ADDR_W-1:0] ibus_rdata;

    modport master (
        output ibus_req, ibus_addr,
        input  ibus_addr_ok, ibus_data_ok, ibus_rdata
    );

    modport slave (
        input  ibus_req, ibus_addr,
        output ibus_addr_ok, ibus_data_ok, ibus_rdata
    );
endinterface

// File: rtl/fetch_npc_sel.sv
// Next fetch-PC priority select (combinational).
//   flush/flush_pc       : redirect, highest priority
//   br_flag/br_addr      : branch resolved this cycle
//   pend_br/pend_addr    : branch buffered from an earlier cycle
//   fetch_pc             : current fetch PC
//   next_pc              : value fetch_pc takes on flush or advance
//   clr_pend             : pending branch is cancelled regardless of advance
module fetch_npc_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W
) (
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              br_flag,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              pend_br,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              clr_pend
);

    always_comb begin
        next_pc = fetch_pc + ADDR_W'(4);
        if (flush)        next_pc = flush_pc;
        else if (br_flag) next_pc = br_addr;     // same-cycle branch bypasses the buffer
        else if (pend_br) next_pc = pend_addr;
    end

    assign clr_pend = flush;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the ibus handshake
// with at most one request outstanding, and fills a one-entry output slot.
//   clk, rstn          : clock, async active-low reset
//   stall              : decode cannot take the slot this cycle
//   flush, flush_pc    : redirect pulse and target
//   br_flag, br_addr   : taken branch pulse and target
//   ibus               : instruction bus (master side)
//   if_valid/pc/inst   : output slot
//   if_excp_ade        : slot carries a misaligned-fetch address error
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              br_flag,
    input  logic [ADDR_W-1:0] br_addr,
    fetch_ctrl_if.master      ibus,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_inst,
    output logic              if_excp_ade
);

    fetch_st_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_pend_br;
    logic [ADDR_W-1:0] r_pend_addr;

    logic              w_slot_free;
    logic              w_misalign;
    logic              w_req;
    logic [ADDR_W-1:0] w_ibus_addr;
    logic              w_load;
    logic              w_load_ade;
    logic              w_adv;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_clr_pend;

    // Only request when the slot can take the result, so the slot is
    // guaranteed empty by the time data comes back.
    assign w_slot_free = !if_valid || !stall;
    assign w_misalign  = (r_fetch_pc[1:0] != 2'b00);

    fetch_npc_sel #(.ADDR_W(ADDR_W)) u_npc_sel (
        .flush     (flush),
        .flush_pc  (flush_pc),
        .br_flag   (br_flag),
        .br_addr   (br_addr),
        .pend_br   (r_pend_br),
        .pend_addr (r_pend_addr),
        .fetch_pc  (r_fetch_pc),
        .next_pc   (w_next_pc),
        .clr_pend  (w_clr_pend)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_ibus_addr = '0;
        w_load      = 1'b0;
        w_load_ade  = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
                w_ibus_addr = r_fetch_pc;
                w_req       = w_slot_free && !w_misalign;
                if (w_misalign) begin
                    // Misaligned PC never reaches the bus; it becomes an
                    // address-error slot and fetch moves on.
                    if (w_slot_free && !flush) begin
                        w_load     = 1'b1;
                        w_load_ade = 1'b1;
                        w_adv      = 1'b1;
                    end
                end else if (w_req && ibus.ibus_addr_ok) begin
                    w_state_nxt = flush ? ST_DISCARD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ibus.ibus_data_ok) begin
                    w_state_nxt = ST_REQ;
                    if (!flush) begin
                        w_load = 1'b1;
                        w_adv  = 1'b1;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // A flush here only retargets fetch_pc; the stale reply
                // still has to be absorbed before a new request.
                if (ibus.ibus_data_ok) w_state_nxt = ST_REQ;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign ibus.ibus_req  = w_req;
    assign ibus.ibus_addr = w_ibus_addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fetch_pc  <= RESET_PC;
            r_pend_br   <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            if (flush || w_adv) r_fetch_pc <= w_next_pc;
            // An advance consumes the buffered branch; a branch arriving
            // on an advance cycle went straight into next_pc.
            if (w_clr_pend || w_adv) begin
                r_pend_br <= 1'b0;
            end else if (br_flag) begin
                r_pend_br   <= 1'b1;
                r_pend_addr <= br_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_inst     <= '0;
            if_excp_ade <= 1'b0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (w_load) begin
            if_valid    <= 1'b1;
            if_pc       <= r_fetch_pc;
            if_inst     <= w_load_ade ? '0 : ibus.ibus_rdata;
            if_excp_ade <= w_load_ade;
        end else if (!stall) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, br_flag = 1'b0;
  logic [31:0] flush_pc = '0, br_addr = '0;
  logic        if_valid, if_excp_ade;
  logic [31:0] if_pc, if_inst;

  fetch_ctrl_if #(.ADDR_W(32)) bus ();

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_flag(br_flag), .br_addr(br_addr), .ibus(bus),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_excp_ade(if_excp_ade)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic ade; } slot_t;

  int n_chk = 0, n_pass = 0;
  slot_t       sb[$];
  logic [31:0] log_q[$];
  logic [31:0] dlv_q[$];

  // reference model: fetch stream in terms of next address, buffered
  // branch, one outstanding request and slot occupancy
  bit          m_started, m_pend, m_busy, m_cancel, m_full;
  logic [31:0] m_pc, m_paddr, m_req_pc;

  // bus slave
  bit          s_busy = 0;
  int          s_cnt = 0;
  logic [31:0] s_addr = '0;
  int          g_lat = 0, g_aok = 100;
  bit          g_rand_lat = 0, g_hold = 0, g_release = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_started = 0; m_pend = 0; m_busy = 0; m_cancel = 0; m_full = 0;
    m_pc = 32'hBFC0_0000; m_paddr = '0; m_req_pc = '0;
    sb.delete();
  endtask

  task automatic model_step();
    bit sf, er, adv, load, consumed;
    sf = !m_full || !stall;
    er = m_started && !m_busy && (m_pc[1:0] == 2'b00) && sf;
    chk("ibus_req", {31'd0, bus.ibus_req}, {31'd0, er});
    if (er) chk("ibus_addr", bus.ibus_addr, m_pc);
    adv = 0; load = 0;
    if (flush) begin
      if (m_busy) begin
        if (bus.ibus_data_ok) m_busy = 0;
        else m_cancel = 1;
      end else if (er && bus.ibus_addr_ok) begin
        m_busy = 1; m_cancel = 1;
      end
      if (m_full && stall && sb.size() > 0) void'(sb.pop_front());
      m_pc = flush_pc; m_pend = 0; m_full = 0;
    end else begin
      consumed = m_full && !stall;
      if (m_busy) begin
        if (bus.ibus_data_ok) begin
          if (!m_cancel) begin
            sb.push_back('{pc: m_req_pc, inst: inst_of(m_req_pc), ade: 1'b0});
            load = 1; adv = 1;
          end
          m_busy = 0; m_cancel = 0;
        end
      end else if (m_started && m_pc[1:0] != 2'b00) begin
        if (sf) begin
          sb.push_back('{pc: m_pc, inst: 32'd0, ade: 1'b1});
          load = 1; adv = 1;
        end
      end else if (er && bus.ibus_addr_ok) begin
        m_busy = 1; m_cancel = 0; m_req_pc = m_pc;
      end
      if (adv) begin
        m_pc = br_flag ? br_addr : (m_pend ? m_paddr : m_pc + 32'd4);
        m_pend = 0;
      end else if (br_flag) begin
        m_pend = 1; m_paddr = br_addr;
      end
      if (load) m_full = 1;
      else if (consumed) m_full = 0;
    end
    m_started = 1;
  endtask

  task automatic step(input bit st, input bit fl, input logic [31:0] fpc,
                      input bit br, input logic [31:0] baddr);
    @(posedge clk); #1;
    if (g_release) begin rstn = 1'b1; g_release = 0; end
    stall = st | (g_hold & if_valid);
    flush = fl; flush_pc = fpc; br_flag = br; br_addr = baddr;
    if (s_busy && s_cnt == 0) begin
      bus.ibus_data_ok = 1'b1; bus.ibus_rdata = inst_of(s_addr);
    end else begin
      bus.ibus_data_ok = 1'b0; bus.ibus_rdata = $urandom;
      if (s_busy) s_cnt--;
    end
    #1;
    bus.ibus_addr_ok = ($urandom_range(99) < g_aok);
    #1;
    model_step();
    if (bus.ibus_data_ok) s_busy = 0;
    if (bus.ibus_req && bus.ibus_addr_ok) begin
      s_busy = 1; s_addr = bus.ibus_addr;
      s_cnt = g_rand_lat ? int'($urandom_range(3)) : g_lat;
      log_q.push_back(bus.ibus_addr);
    end
  endtask

  task automatic step0();
    step(0, 0, 32'd0, 0, 32'd0);
  endtask

  task automatic run_until_log(input int n);
    for (int i = 0; i < 60 && log_q.size() < n; i++) step0();
    chk("reach_request_count", {31'd0, log_q.size() >= n}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ibus_req"}, {31'd0, bus.ibus_req}, 32'd0);
    chk({tag, "_ibus_addr"}, bus.ibus_addr, 32'd0);
    chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_if_inst"}, if_inst, 32'd0);
    chk({tag, "_if_ade"}, {31'd0, if_excp_ade}, 32'd0);
  endtask

  // scoreboard monitor: every slot the decode stage takes is compared
  always @(negedge clk) begin : mon
    slot_t e;
    if (rstn && if_valid && !stall) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL slot_unexpected: if_pc=%h with nothing expected at %0t", if_pc, $time);
      end else begin
        e = sb.pop_front();
        chk("slot_pc", if_pc, e.pc);
        chk("slot_inst", if_inst, e.inst);
        chk("slot_ade", {31'd0, if_excp_ade}, {31'd0, e.ade});
      end
      dlv_q.push_back(if_pc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int          held, cnt;
    logic [31:0] cap_pc, cap_inst, fpc;
    bit          fl, br;
    bus.ibus_addr_ok = 0; bus.ibus_data_ok = 0; bus.ibus_rdata = '0;
    model_reset();

    // reset state
    @(posedge clk); #2;
    chk_reset_outputs("reset");
    g_release = 1; step0();          // IDLE cycle

    // sequential fetch, 1-cycle handshakes
    g_lat = 0; g_aok = 100;
    for (int i = 0; i < 40 && log_q.size() < 3; i++) begin
      if (log_q.size() == 2) g_lat = 3;
      step0();
    end
    chk("req0", log_q[0], 32'hBFC0_0000);
    chk("req1", log_q[1], 32'hBFC0_0004);
    chk("req2", log_q[2], 32'hBFC0_0008);

    // branch buffered, then flush during WAIT drops word and branch
    step(0, 0, 32'd0, 1, 32'h8000_1000);
    step(0, 1, 32'h8000_0180, 0, 32'd0);
    g_lat = 0;
    run_until_log(5);
    chk("req_after_flush", log_q[3], 32'h8000_0180);
    chk("pend_br_discarded", log_q[4], 32'h8000_0184);

    // branch while delay slot in flight
    step(0, 0, 32'd0, 1, 32'h8000_1000);
    run_until_log(7);
    chk("br_target", log_q[5], 32'h8000_1000);
    chk("br_target_seq", log_q[6], 32'h8000_1004);
    cnt = 0;
    foreach (dlv_q[i]) if (dlv_q[i] == 32'hBFC0_0008) cnt++;
    chk("flushed_word_dropped", cnt, 0);

    // stall with a full slot
    g_hold = 1; held = 0;
    for (int i = 0; i < 40 && held < 5; i++) begin
      step0();
      if (stall && if_valid) begin
        if (held == 0) begin cap_pc = if_pc; cap_inst = if_inst; end
        chk("stall_no_req", {31'd0, bus.ibus_req}, 32'd0);
        chk("stall_pc_stable", if_pc, cap_pc);
        chk("stall_inst_stable", if_inst, cap_inst);
        held++;
      end
    end
    chk("stall_cycles", held, 5);
    g_hold = 0;
    step0();
    chk("req_after_stall", {31'd0, bus.ibus_req}, 32'd1);

    // misaligned redirect
    g_aok = 0;
    for (int i = 0; i < 10 && s_busy; i++) step0();
    step(0, 1, 32'h8000_0182, 0, 32'd0);
    step0();
    chk("mis_no_req", {31'd0, bus.ibus_req}, 32'd0);
    step0();
    chk("mis_valid", {31'd0, if_valid}, 32'd1);
    chk("mis_pc", if_pc, 32'h8000_0182);
    chk("mis_ade", {31'd0, if_excp_ade}, 32'd1);
    chk("mis_inst", if_inst, 32'd0);
    step0();
    chk("mis_next_pc", if_pc, 32'h8000_0186);
    chk("mis_next_ade", {31'd0, if_excp_ade}, 32'd1);

    // address wrap
    g_aok = 100;
    step(0, 1, 32'hFFFF_FFFC, 0, 32'd0);
    cnt = log_q.size();
    run_until_log(cnt + 2);
    chk("wrap_last", log_q[cnt], 32'hFFFF_FFFC);
    chk("wrap_zero", log_q[cnt + 1], 32'h0000_0000);

    // reset during WAIT, late data_ok ignored
    g_lat = 5;
    for (int i = 0; i < 20 && !s_busy; i++) step0();
    step0();
    #1 rstn = 1'b0;
    #1 chk_reset_outputs("midreset");
    model_reset();
    s_cnt = 0;
    log_q.delete();
    g_lat = 0;
    g_release = 1; step0();
    run_until_log(1);
    chk("req_after_reset", log_q[0], 32'hBFC0_0000);

    // randomized traffic
    g_aok = 75; g_rand_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      fl = ($urandom_range(99) < 4);
      fpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(9) == 0) fpc[1:0] = 2'($urandom_range(3, 1));
      br = !fl && !m_pend && ($urandom_range(99) < 8);
      step($urandom_range(99) < 30, fl, fpc, br, $urandom & 32'hFFFF_FFFC);
    end

    // drain
    g_aok = 0;
    step(0, 1, 32'h0000_1000, 0, 32'd0);
    for (int i = 0; i < 8; i++) step0();
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_if_valid", {31'd0, if_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
